// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - line, configuration, edge/bit counter and byte-output signals of the UART receive FSM
// The FSM binds to the slave modport; the counter/driver side binds to master.
interface uart_rx_fsm_if;
   logic       RX_IN;
   logic [5:0] prescaler;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [4:0] Edge_Counter;
   logic [2:0] Bit_Counter;
   logic       Done;
   logic       Edge_EN_CNT;
   logic       Bit_EN_CNT;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       Parity_Error;
   logic       Stop_Error;

   modport slave (
      input  RX_IN, prescaler, PAR_EN, PAR_TYP,
      input  Edge_Counter, Bit_Counter, Done,
      output Edge_EN_CNT, Bit_EN_CNT,
      output P_DATA, Data_Valid, Parity_Error, Stop_Error
   );

   modport master (
      output RX_IN, prescaler, PAR_EN, PAR_TYP,
      output Edge_Counter, Bit_Counter, Done,
      input  Edge_EN_CNT, Bit_EN_CNT,
      input  P_DATA, Data_Valid, Parity_Error, Stop_Error
   );
endinterface

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive FSM: majority-vote sampling, LSB-first deserialiser, parity/stop check
// Optional macro RX_IN_SYNC_EN inserts a 2-flop synchroniser on RX_IN.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8
) (
   input  logic          CLK,
   input  logic          RST,
   uart_rx_fsm_if.slave  bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

   logic                  rx_line;
   logic [2:0]            state;
   logic [2:0]            state_nxt;
   logic                  edge_en;
   logic                  bit_en;
   logic [5:0]            half;
   logic [5:0]            edge_cnt;
   logic                  s0, s1, s2;
   logic                  sampled_bit;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] p_data_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  par_bad;
   logic                  data_valid_q;
   logic                  parity_err_q;
   logic                  stop_err_q;

`ifdef RX_IN_SYNC_EN
   logic [1:0] sync_q;

   // Flops reset to the idle line level so reset release never looks like a start bit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], bus.RX_IN};
      end
   end

   assign rx_line = sync_q[1];
`else
   assign rx_line = bus.RX_IN;
`endif

   assign half     = bus.prescaler >> 1;
   assign edge_cnt = {1'b0, bus.Edge_Counter};

   assign edge_en = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);
   assign bit_en  = (state == DATA);

   assign bus.Edge_EN_CNT  = edge_en;
   assign bus.Bit_EN_CNT   = bit_en;
   assign bus.P_DATA       = p_data_q;
   assign bus.Data_Valid   = data_valid_q;
   assign bus.Parity_Error = parity_err_q;
   assign bus.Stop_Error   = stop_err_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!rx_line) begin
               state_nxt = START;
            end
         end
         START: begin
            if (bus.Done) begin
               state_nxt = sampled_bit ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bus.Done && (bus.Bit_Counter == LAST_BIT)) begin
               state_nxt = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bus.Done) begin
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (bus.Done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Three samples straddle mid-bit; the vote lands one edge later, well before Done.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s0          <= 1'b0;
         s1          <= 1'b0;
         s2          <= 1'b0;
         sampled_bit <= 1'b0;
      end else if (edge_en) begin
         if (edge_cnt == half - 6'd2) begin
            s0 <= rx_line;
         end
         if (edge_cnt == half - 6'd1) begin
            s1 <= rx_line;
         end
         if (edge_cnt == half) begin
            s2 <= rx_line;
         end
         if (edge_cnt == half + 6'd1) begin
            sampled_bit <= (s0 & s1) | (s1 & s2) | (s0 & s2);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_reg    <= '0;
         p_data_q     <= '0;
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_bad      <= 1'b0;
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         stop_err_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_line) begin
                  par_en_q  <= bus.PAR_EN;
                  par_typ_q <= bus.PAR_TYP;
                  par_bad   <= 1'b0;
               end
            end
            DATA: begin
               if (bus.Done) begin
                  shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
               end
            end
            PARITY: begin
               if (bus.Done) begin
                  par_bad <= sampled_bit ^ (par_typ_q ? ~(^shift_reg) : (^shift_reg));
               end
            end
            STOP: begin
               if (bus.Done) begin
                  stop_err_q   <= ~sampled_bit;
                  parity_err_q <= par_bad;
                  if (sampled_bit && !par_bad) begin
                     data_valid_q <= 1'b1;
                     p_data_q     <= shift_reg;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Control and datapath stage for the UART receiver. It drives the enables of the edge/bit counter and consumes that counter's Edge_Counter, Bit_Counter and Done outputs. It also performs 3-sample majority voting on RX_IN, deserialises 8 data bits LSB-first, checks optional parity and the stop bit, and presents a validated byte with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 8, payload bits per frame; fixed at 8 and matched to the 3-bit Bit_Counter.

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous reset, active-high
RX_IN  input  1  serial line; idle high
prescaler  input  6  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
Edge_Counter  input  5  from edge/bit counter
Bit_Counter  input  3  from edge/bit counter
Done  input  1  from edge/bit counter; high when Edge_Counter == prescaler-1
Edge_EN_CNT  output  1  edge counter enable
Bit_EN_CNT  output  1  bit counter enable; counter clears when this is low
P_DATA  output  8  last validated byte
Data_Valid  output  1  one-cycle pulse when a good frame completes
Parity_Error  output  1  one-cycle pulse; parity mismatch at end of frame
Stop_Error  output  1  one-cycle pulse; stop bit sampled 0

Behaviour:
- Reset: state = IDLE. P_DATA = 0x00. Data_Valid, Parity_Error, Stop_Error = 0. Shift register, sample flops and latched PAR_EN/PAR_TYP all cleared. Reset asserted mid-frame aborts the frame immediately with no output pulse.
- Enables are decoded combinationally from state:
  - Edge_EN_CNT = 1 in START, DATA, PARITY and STOP.
  - Bit_EN_CNT = 1 only in DATA.
- Sampling:
  - Capture RX_IN when Edge_Counter equals P/2-2, P/2-1 and P/2.
  - At Edge_Counter == P/2+1, register sampled_bit = majority of the three samples.
  - sampled_bit is stable before Done for all legal prescaler values.
- States:
  - IDLE: on RX_IN == 0, go to START and latch PAR_EN and PAR_TYP for the frame. The counter's first enabled cycle is Edge_Counter = 0.
  - START: on Done, if sampled_bit == 1 (glitch), go to IDLE with no pulse; otherwise go to DATA.
  - DATA: on Done, shift sampled_bit into bit 7 of the shift register (shift right, LSB-first). On Done with Bit_Counter == 7, go to PARITY if the latched PAR_EN is 1, else go to STOP. The 3-bit Bit_Counter wraps 7 to 0 and is cleared by Bit_EN_CNT falling.
  - PARITY: on Done, register par_bad = sampled_bit XOR expected, then go to STOP.
    - Expected parity for even: XOR of the 8 data bits.
    - Expected parity for odd: XNOR of the 8 data bits.
    - par_bad = 0 when parity is disabled.
  - STOP: on Done, go to IDLE and, in the cycle following Done:
    - Stop_Error = ~sampled_bit.
    - Parity_Error = par_bad.
    - Data_Valid = 1 only if both errors are 0; P_DATA loads the shift register in that same cycle.
- P_DATA holds its value across bad frames and glitches.
- Back-to-back frames: a start edge arriving while in STOP is detected in IDLE one cycle later. A 1-cycle offset against a half-bit margin is acceptable.
- Changing prescaler mid-frame is unsupported. PAR_EN/PAR_TYP changes take effect only at the next frame.
- Illegal state encodings recover to IDLE.

Optional Feature:
Macro RX_IN_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchroniser (flops reset to 1) before use in sampling and start detection. This adds 2 cycles of latency from line transition to FSM reaction.
- Undefined: RX_IN is used directly; the input is assumed synchronous to CLK.

Test Plan:
- prescaler=8, PAR_EN=0, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> one Data_Valid pulse, P_DATA=0xA5, no error pulses.
- prescaler=16, PAR_EN=1, PAR_TYP=0, byte 0x37 with parity bit 1 -> Data_Valid with P_DATA=0x37. Same byte with parity bit 0 -> Parity_Error pulse, no Data_Valid, P_DATA stays 0x37.
- prescaler=32, byte 0x00 with stop bit 0 -> Stop_Error pulse, no Data_Valid.
- RX_IN low for 2 cycles only with prescaler=16 -> START then IDLE at Done, no pulses, counter enables deassert.
- Two back-to-back frames 0x55 then 0xC3 with prescaler=8 and odd parity -> two Data_Valid pulses with the correct bytes.
- Assert RST mid-DATA -> outputs at reset values, Edge_EN_CNT=0; the next clean frame 0x81 is received correctly.
